// File: rtl/adsr_volume_gen.sv
// ADSR envelope volume generator: two-stage update pipeline with a per-phase
// sample prescaler, clamped attack/decay/release arithmetic and overrun flag.
module adsr_volume_gen #(
    parameter logic [17:0] VOLUME_MAX = 18'h1FFFF,
    parameter int          DIV_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_sample,
    input  logic [4:0]       state,
    input  logic [17:0]      volume_d,
    input  logic [17:0]      sustain_value,
    input  logic [17:0]      attack_step,
    input  logic [17:0]      decay_step,
    input  logic [17:0]      release_step,
    input  logic [DIV_W-1:0] attack_div,
    input  logic [DIV_W-1:0] decay_div,
    input  logic [DIV_W-1:0] release_div,
    output logic [17:0]      volume,
    output logic             volume_valid,
    output logic             busy,
    output logic             overrun
);

    localparam logic [2:0] PH_ATTACK  = 3'd1;
    localparam logic [2:0] PH_DECAY   = 3'd2;
    localparam logic [2:0] PH_SUSTAIN = 3'd3;
    localparam logic [2:0] PH_RELEASE = 3'd4;
    localparam logic [2:0] PH_BLANK   = 3'd5;

    typedef struct packed {
        logic [2:0]       phase;
        logic [17:0]      base;
        logic [17:0]      sustain;
        logic [17:0]      a_step;
        logic [17:0]      d_step;
        logic [17:0]      r_step;
        logic [DIV_W-1:0] a_div;
        logic [DIV_W-1:0] d_div;
        logic [DIV_W-1:0] r_div;
    } capt_t;

    capt_t            cap_q, cap_d;
    logic             valid1_q, valid1_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       last_phase_q, last_phase_d;
    logic [17:0]      vol_out_q, vol_out_d;
    logic             vol_valid_q, vol_valid_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             advance;
    logic             tick;
    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] pos;
    logic [18:0]      sum_a;
    logic [18:0]      diff_d;
    logic [18:0]      diff_r;
    logic [17:0]      next_vol;

    // The note/release latch bits are informational only here.
    logic unused_latch_bits;
    assign unused_latch_bits = ^state[4:3];

    assign busy   = valid1_q | vol_valid_q;
    assign accept = new_sample & ~busy;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cap_d        = cap_q;
        valid1_d     = accept;
        overrun_d    = overrun_q | (new_sample & busy);
        cnt_d        = cnt_q;
        last_phase_d = last_phase_q;
        vol_out_d    = vol_out_q;
        vol_valid_d  = 1'b0;
        advance      = 1'b0;
        div_sel      = '0;
        next_vol     = '0;

        if (accept) begin
            cap_d.phase   = state[2:0];
            cap_d.base    = volume_d;
            cap_d.sustain = sustain_value;
            cap_d.a_step  = attack_step;
            cap_d.d_step  = decay_step;
            cap_d.r_step  = release_step;
            cap_d.a_div   = attack_div;
            cap_d.d_div   = decay_div;
            cap_d.r_div   = release_div;
        end

        case (cap_q.phase)
            PH_ATTACK:  begin advance = 1'b1; div_sel = cap_q.a_div; end
            PH_DECAY:   begin advance = 1'b1; div_sel = cap_q.d_div; end
            PH_RELEASE: begin advance = 1'b1; div_sel = cap_q.r_div; end
            default:    begin advance = 1'b0; div_sel = '0;          end
        endcase

        // A phase change restarts the prescaler count for this sample.
        pos  = (cap_q.phase != last_phase_q) ? '0 : cnt_q;
        tick = advance && (pos == div_sel);

        // Bit 18 of each difference is the borrow, i.e. the result went negative.
        sum_a  = {1'b0, cap_q.base} + {1'b0, cap_q.a_step};
        diff_d = {1'b0, cap_q.base} - {1'b0, cap_q.d_step};
        diff_r = {1'b0, cap_q.base} - {1'b0, cap_q.r_step};

        case (cap_q.phase)
            PH_ATTACK: begin
                if (!tick)
                    next_vol = cap_q.base;
                else if (sum_a > {1'b0, VOLUME_MAX})
                    next_vol = VOLUME_MAX;
                else
                    next_vol = sum_a[17:0];
            end
            PH_DECAY: begin
                if (cap_q.base <= cap_q.sustain)
                    next_vol = cap_q.sustain;
                else if (!tick)
                    next_vol = cap_q.base;
                else if (diff_d[18] || (diff_d[17:0] < cap_q.sustain))
                    next_vol = cap_q.sustain;
                else
                    next_vol = diff_d[17:0];
            end
            PH_SUSTAIN: next_vol = cap_q.sustain;
            PH_RELEASE: begin
                if (cap_q.base[17])
                    next_vol = '0;
                else if (!tick)
                    next_vol = cap_q.base;
                else if (diff_r[18])
                    next_vol = '0;
                else
                    next_vol = diff_r[17:0];
            end
            default: next_vol = '0;
        endcase

        if (valid1_q) begin
            vol_valid_d  = 1'b1;
            vol_out_d    = next_vol;
            last_phase_d = cap_q.phase;
            if (!advance)
                cnt_d = '0;
            else if (tick)
                cnt_d = '0;
            else
                cnt_d = pos + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q     <= 1'b0;
            cnt_q        <= '0;
            last_phase_q <= PH_BLANK;
            vol_out_q    <= '0;
            vol_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            valid1_q     <= valid1_d;
            cnt_q        <= cnt_d;
            last_phase_q <= last_phase_d;
            vol_out_q    <= vol_out_d;
            vol_valid_q  <= vol_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // NOTE: the captured operands need no reset; they are only consumed when
    // valid1_q is set, and valid1_q itself is reset.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    assign volume       = vol_out_q;
    assign volume_valid = vol_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adsr_volume_gen.sv
// Scoreboard bench for adsr_volume_gen: stimulus pushes reference-model
// volumes into a queue, a negedge monitor pops them on every volume_valid.
module tb_adsr_volume_gen;

    localparam int VMAX = 'h1FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_sample;
    logic [4:0]  state;
    logic [17:0] volume_d, sustain_value, attack_step, decay_step, release_step;
    logic [7:0]  attack_div, decay_div, release_div;
    logic [17:0] volume;
    logic        volume_valid, busy, overrun;

    adsr_volume_gen dut (
        .clk          (clk),
        .rst          (rst),
        .new_sample   (new_sample),
        .state        (state),
        .volume_d     (volume_d),
        .sustain_value(sustain_value),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .release_step (release_step),
        .attack_div   (attack_div),
        .decay_div    (decay_div),
        .release_div  (release_div),
        .volume       (volume),
        .volume_valid (volume_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vol;
        int dir;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_cnt  = 0;
    int   m_last = 5;
    int   last_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour: tick when the samples counted in the current phase
    // reach that phase's divider; volume follows the clamped phase rules.
    function automatic int model(input int ph, input int vd, input int sus,
                                 input int a_st, input int d_st, input int r_st,
                                 input int a_dv, input int d_dv, input int r_dv);
        int  div, pos, res;
        bit  adv, tick;
        adv  = (ph == 1) || (ph == 2) || (ph == 4);
        div  = (ph == 1) ? a_dv : (ph == 2) ? d_dv : r_dv;
        pos  = (ph != m_last) ? 0 : m_cnt;
        tick = adv && (pos == div);
        m_cnt  = (!adv || tick) ? 0 : (pos + 1) % 256;
        m_last = ph;
        case (ph)
            1: res = !tick ? vd : ((vd + a_st > VMAX) ? VMAX : vd + a_st);
            2: begin
                if (vd <= sus)      res = sus;
                else if (!tick)     res = vd;
                else                res = (vd - d_st < sus) ? sus : vd - d_st;
            end
            3: res = sus;
            4: begin
                if (vd >= 'h20000)  res = 0;
                else if (!tick)     res = vd;
                else                res = (vd - r_st < 0) ? 0 : vd - r_st;
            end
            default: res = 0;
        endcase
        return res;
    endfunction

    task automatic scramble_inputs();
        state         = 5'($urandom);
        volume_d      = 18'($urandom);
        sustain_value = 18'($urandom);
        attack_step   = 18'($urandom);
        decay_step    = 18'($urandom);
        release_step  = 18'($urandom);
        attack_div    = 8'($urandom);
        decay_div     = 8'($urandom);
        release_div   = 8'($urandom);
    endtask

    task automatic send(input int ph, input int vd, input int sus,
                        input int a_st, input int d_st, input int r_st,
                        input int a_dv, input int d_dv, input int r_dv,
                        input int dir, output int vout);
        @(posedge clk); #1;
        state         = {2'($urandom_range(0, 3)), 3'(ph)};
        volume_d      = 18'(vd);
        sustain_value = 18'(sus);
        attack_step   = 18'(a_st);
        decay_step    = 18'(d_st);
        release_step  = 18'(r_st);
        attack_div    = 8'(a_dv);
        decay_div     = 8'(d_dv);
        release_div   = 8'(r_dv);
        new_sample    = 1'b1;
        vout = model(ph, vd, sus, a_st, d_st, r_st, a_dv, d_dv, r_dv);
        exp_q.push_back('{vout, dir});
        @(posedge clk); #1;
        new_sample = 1'b0;
        scramble_inputs();
        check("busy_n1", busy, 1);
        check("vol_hold", volume, last_exp);
        @(posedge clk); #1;
        check("busy_n2", busy, 1);
        last_exp = vout;
    endtask

    initial begin : monitor
        int   prev;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
            end else if (volume_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("volume", volume, e.vol);
                    if (e.dir > 0) check("mono_up", int'(volume) >= prev, 1);
                    if (e.dir < 0) check("mono_down", int'(volume) <= prev, 1);
                    prev = int'(volume);
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int v, ph, vd, run, k, dir;
        bit done;

        rst = 1'b1;
        new_sample = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_volume", volume, 0);
        check("rst_valid", volume_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Attack clamps at the ceiling.
        send(1, 'h18000, 0, 'h10000, 0, 0, 0, 0, 0, 0, v);

        // Decay divider 3: three warm-up samples, then ticks on samples 1 and 5.
        v = 'h1000;
        for (int i = 0; i < 11; i++)
            send(2, v, 'h0C00, 0, 'h100, 0, 0, 3, 0, 0, v);

        // Decay floored at sustain.
        send(3, 0, 'h0C00, 0, 0, 0, 0, 0, 0, 0, v);
        send(2, 'h0C80, 'h0C00, 0, 'h100, 0, 0, 0, 0, 0, v);

        // Release floors at zero, and top-bit volume goes straight to zero.
        send(4, 'h0100, 0, 0, 0, 'h200, 0, 0, 0, 0, v);
        send(4, 'h20000, 0, 0, 0, 'h200, 0, 0, 0, 0, v);

        // Zero attack step stalls.
        send(1, 'h5000, 0, 0, 0, 0, 0, 0, 0, 0, v);

        // Randomized phases, operands and dividers.
        ph = 1;
        run = 0;
        v = 0;
        for (int i = 0; i < 200; i++) begin
            if (run == 0) begin
                ph  = $urandom_range(0, 7);
                run = $urandom_range(1, 8);
            end
            run--;
            vd = ($urandom_range(0, 1) == 1) ? v : int'($urandom_range(0, 'h3FFFF));
            send(ph, vd, $urandom_range(0, 'h3FFFF),
                 $urandom_range(0, 'h3FFFF) >> $urandom_range(0, 10),
                 $urandom_range(0, 'h3FFFF) >> $urandom_range(0, 10),
                 $urandom_range(0, 'h3FFFF) >> $urandom_range(0, 10),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 3),
                 0, v);
        end

        // Closed loop: note-on, release after 50 samples, back to blank.
        send(5, 0, 'h10000, 'h4000, 'h1000, 'h2000, 1, 0, 2, 0, v);
        ph = 1;
        done = 1'b0;
        k = 0;
        while (k < 200 && !done) begin
            if (k == 50) ph = 4;
            dir = (ph == 1) ? 1 : -1;
            send(ph, v, 'h10000, 'h4000, 'h1000, 'h2000, 1, 0, 2, dir, v);
            case (ph)
                1: if (v >= VMAX) ph = 2;
                2: if (v <= 'h10000) ph = 3;
                4: if (v == 0) done = 1'b1;
                default: ;
            endcase
            k++;
        end
        check("loop_reached_blank", done, 1);
        send(5, v, 'h10000, 'h4000, 'h1000, 'h2000, 1, 0, 2, 0, v);

        // Back-to-back pulses: second is dropped and overrun latches.
        @(posedge clk); #1;
        state = 5'd1; volume_d = 18'h00100; attack_step = 18'h00080; attack_div = 8'd0;
        new_sample = 1'b1;
        v = model(1, 'h100, 0, 'h80, 0, 0, 0, 0, 0);
        exp_q.push_back('{v, 0});
        @(posedge clk); #1;
        check("ovr_busy_n1", busy, 1);
        @(posedge clk); #1;
        new_sample = 1'b0;
        check("overrun_set", overrun, 1);
        @(posedge clk); #1;
        check("overrun_sticky", overrun, 1);
        check("ovr_idle", busy, 0);
        last_exp = v;

        // Reset during an update aborts it without a valid pulse.
        @(posedge clk); #1;
        state = 5'd1; volume_d = 18'h01000; attack_step = 18'h00100; attack_div = 8'd0;
        new_sample = 1'b1;
        @(posedge clk); #1;
        new_sample = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_volume", volume, 0);
        check("abort_valid", volume_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        m_last = 5;
        last_exp = 0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_valid_vol", volume, 0);

        // First sample after reset is processed normally.
        send(1, 'h0100, 0, 'h0100, 0, 0, 0, 0, 0, 0, v);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adsr_volume_gen.md
ADSR_VOLUME_GEN -- requirements
Module: adsr_volume_gen

Interface
REQ-001 Parameter VOLUME_MAX, default 18'h1FFFF, attack ceiling; matches adsr_mngt attack-exit threshold.
REQ-002 Parameter DIV_W, default 8, width of per-phase rate dividers.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 new_sample  input  1  one-cycle pulse per audio sample, same pulse as fed to adsr_mngt.
REQ-006 state  input  5  from adsr_mngt: [2:0] phase (1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE, 5 BLANK); [3] new-note latch; [4] release latch.
REQ-007 volume_d  input  18  registered volume from adsr_mngt, the base of each update.
REQ-008 sustain_value  input  18  sustain level, unsigned.
REQ-009 attack_step, decay_step, release_step  input  18 each  per-tick increments, unsigned.
REQ-010 attack_div, decay_div, release_div  input  DIV_W each  samples per tick minus one.
REQ-011 volume  output  18  next envelope volume to adsr_mngt.
REQ-012 volume_valid  output  1  one-cycle pulse when volume updates.
REQ-013 busy  output  1  high while an update is in flight.
REQ-014 overrun  output  1  sticky: new_sample arrived while busy.

Function
REQ-015 Two-stage pipeline: cycle N new_sample captures state[2:0], volume_d, steps, divs, sustain_value; cycle N+1 computes; volume and volume_valid are registered at the end of cycle N+1, visible from cycle N+2.
REQ-016 busy is high in cycles N+1 and N+2; volume holds between updates.
REQ-017 new_sample while busy is dropped; overrun sets and stays set until reset.
REQ-018 Prescaler: one DIV_W counter plus a registered last-phase; a sample is a tick when counter == the current phase's div; on a tick the counter clears, otherwise it increments.
REQ-019 When the captured phase differs from the last phase, the counter is treated as 0 for that sample, and the last phase updates.
REQ-020 div = 0: every sample is a tick; div = 255: one tick per 256 samples.
REQ-021 Counter advances only in ATTACK, DECAY and RELEASE; it is held at 0 in SUSTAIN, BLANK and undefined codes.
REQ-022 Arithmetic uses a 19-bit intermediate; no wrap is permitted.
REQ-023 ATTACK tick: volume = min(volume_d + attack_step, VOLUME_MAX); non-tick: volume = volume_d.
REQ-024 DECAY tick: volume = max(volume_d - decay_step, sustain_value); if volume_d <= sustain_value, volume = sustain_value; non-tick: volume = volume_d.
REQ-025 SUSTAIN: volume = sustain_value every sample.
REQ-026 RELEASE tick: volume = volume_d - release_step, floored at 0; non-tick: volume = volume_d.
REQ-027 RELEASE when volume_d[17] = 1: volume = 0.
REQ-028 BLANK and codes 0, 6, 7: volume = 0.
REQ-029 Retrigger (phase enters ATTACK from DECAY, SUSTAIN or RELEASE): attack starts from the captured volume_d, with no jump to 0.
REQ-030 state[4:3] do not affect arithmetic.
REQ-031 Step and div inputs are sampled only on accepted new_sample; mid-update changes have no effect.
REQ-032 Attack step 0 with volume_d < VOLUME_MAX: volume holds; this is a legal stall, not an error.

Reset
REQ-033 While rst is high: volume = 0, volume_valid = 0, busy = 0, overrun = 0, counter = 0, last phase = BLANK; pipeline contents are discarded.
REQ-034 rst asserted mid-update aborts the update; no volume_valid pulse follows the deassertion.
REQ-035 First new_sample after reset is processed normally.

Verification
REQ-036 ATTACK, attack_div = 0, attack_step = 18'h10000, volume_d = 18'h18000 -> volume = 18'h1FFFF at N+2, one volume_valid pulse.
REQ-037 DECAY, decay_div = 3, decay_step = 18'h100, volume_d = 18'h1000, sustain_value = 18'h0C00, 8 samples -> steps only on samples 1 and 5 (0x0F00, 0x0E00); other samples hold.
REQ-038 DECAY, volume_d = 18'h0C80, decay_step = 18'h100, sustain_value = 18'h0C00 -> volume = 18'h0C00, floored at sustain.
REQ-039 RELEASE, release_step = 18'h200, volume_d = 18'h0100 -> volume = 0; repeat with volume_d = 18'h20000 -> volume = 0.
REQ-040 Closed loop with adsr_mngt: note-on, then release after 50 samples -> phases BLANK, ATTACK, DECAY, SUSTAIN, RELEASE, BLANK; volume monotonic in each phase.
REQ-041 new_sample pulses 1 cycle apart -> second pulse dropped, overrun = 1; rst during busy -> all outputs 0, no stray volume_valid.
